// File: rtl/serial_hba_pkg.sv
// Shared types and constants for the serial-to-HBA command sequencer.
// The header bit positions describe byte 0 = {rnw, num[2:0], addr[11:8]}.
package serial_hba_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        XFER,
        TXS,
        TXW
    } state_t;

    localparam int RNW_BIT = 7;
    localparam int NUM_MSB = 6;
    localparam int NUM_LSB = 4;
    localparam int ADDR_W  = 12;

endpackage

// File: rtl/serial_hba_timeout.sv
// Loadable down-counter watchdog: reloads on clear and flags the last counted cycle.
// LIMIT = 0 disables the watchdog entirely.
module serial_hba_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Fires during the LIMIT-th enabled cycle so the caller aborts on that edge.
    assign expired = (LIMIT != 0) && enable && !clear && (cnt <= CNT_W'(1));

endmodule

// File: rtl/serial_hba_cmd_ctrl.sv
// Serial bridge command sequencer: parses UART header/data bytes, runs 1..8
// auto-incrementing HBA transfers and returns read bytes through the UART.
module serial_hba_cmd_ctrl
    import serial_hba_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT   = 1_000_000,
    parameter int unsigned XFER_TIMEOUT = 255
) (
    input  logic              hba_clk,
    input  logic              hba_reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              read_strobe,
    output logic              write_strobe,
    output logic [7:0]        tx_data,
    input  logic              hba_mgrant,
    input  logic              hba_xferack,
    input  logic [7:0]        hba_dbus,
    output logic              masterx_request,
    output logic [ADDR_W-1:0] master_abus,
    output logic              master_rnw,
    output logic [7:0]        master_dbus,
    output logic              busy,
    output logic              err
);

    state_t            state;
    state_t            state_nxt;
    logic              rnw_q;
    logic [3:0]        remain_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;
    logic              rx_accept;
    logic              pop;
    logic              rx_clr;
    logic              rx_expired;
    logic              xf_expired;
    logic              bus_on;
    logic              abort;

    assign rx_accept = (state == IDLE) || (state == ADDR) || (state == DATA);
    assign pop       = rx_accept && rx_valid && !read_strobe;
    assign rx_clr    = pop || !((state == ADDR) || (state == DATA));

    serial_hba_timeout #(.LIMIT(RX_TIMEOUT)) u_rx_timer (
        .clk     (hba_clk),
        .rst     (hba_reset),
        .clear   (rx_clr),
        .enable  (1'b1),
        .expired (rx_expired)
    );

    serial_hba_timeout #(.LIMIT(XFER_TIMEOUT)) u_xfer_timer (
        .clk     (hba_clk),
        .rst     (hba_reset),
        .clear   (!masterx_request),
        .enable  (1'b1),
        .expired (xf_expired)
    );

    // Bus outputs decode straight from state so reset drops them asynchronously.
    assign masterx_request = (state == REQ) || (state == XFER);
    assign bus_on          = (state == XFER) && hba_mgrant;
    assign master_abus     = bus_on ? addr_q : '0;
    assign master_rnw      = bus_on && rnw_q;
    assign master_dbus     = (bus_on && !rnw_q) ? wdata_q : '0;
    assign busy            = (state != IDLE);

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_nxt = ADDR;
            end
            ADDR: begin
                if (rx_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (pop) begin
                    state_nxt = rnw_q ? REQ : DATA;
                end
            end
            DATA: begin
                if (rx_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (pop) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (xf_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (hba_mgrant) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                // A completing transfer beats a watchdog expiring in the same cycle.
                if (hba_xferack) begin
                    if (rnw_q)                state_nxt = TXS;
                    else if (remain_q > 4'd1) state_nxt = DATA;
                    else                      state_nxt = IDLE;
                end else if (xf_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            TXS: begin
                if (!tx_busy) state_nxt = TXW;
            end
            TXW: begin
                // write_strobe marks the first TXW cycle, where tx_busy is not yet meaningful.
                if (!write_strobe && !tx_busy) state_nxt = (remain_q != 4'd0) ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state        <= IDLE;
            read_strobe  <= 1'b0;
            write_strobe <= 1'b0;
            tx_data      <= '0;
            rnw_q        <= 1'b0;
            remain_q     <= '0;
            addr_q       <= '0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            read_strobe  <= pop;
            write_strobe <= (state == TXS) && !tx_busy;
            if ((state == TXS) && !tx_busy) tx_data <= rdata_q;
            if (pop && (state == IDLE)) begin
                rnw_q                <= rx_data[RNW_BIT];
                remain_q             <= {1'b0, rx_data[NUM_MSB:NUM_LSB]} + 4'd1;
                addr_q[ADDR_W-1:8]   <= rx_data[3:0];
            end
            if (pop && (state == ADDR)) addr_q[7:0] <= rx_data;
            if ((state == XFER) && hba_xferack) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - 4'd1;
            end
            if (abort)                       err <= 1'b1;
            else if (pop && (state == IDLE)) err <= 1'b0;
        end
    end

    // Payload registers carry no reset; they are always written before use.
    always_ff @(posedge hba_clk) begin
        if (pop && (state == DATA)) wdata_q <= rx_data;
        if ((state == XFER) && hba_xferack && rnw_q) rdata_q <= hba_dbus;
    end

endmodule

// File: tb/tb_serial_hba_cmd_ctrl.sv
// Self-checking bench: UART and HBA slave models plus a packet-level reference
// of expected transfers and returned bytes.
module tb_serial_hba_cmd_ctrl;

    logic        hba_clk = 1'b0;
    logic        hba_reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        read_strobe;
    logic        write_strobe;
    logic [7:0]  tx_data;
    logic        hba_mgrant;
    logic        hba_xferack;
    logic [7:0]  hba_dbus;
    logic        masterx_request;
    logic [11:0] master_abus;
    logic        master_rnw;
    logic [7:0]  master_dbus;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  obs_tx[$];
    logic [7:0]  slv_rd[$];
    logic [7:0]  rd_src[$];
    logic [20:0] obs_xfer[$];
    logic [20:0] exp_xfer[$];

    int   tx_cnt   = 0;
    int   gnt_dly  = 0;
    int   ack_dly  = 0;
    logic recorded = 1'b0;
    logic stall_gnt = 1'b0;
    logic hold_ack  = 1'b0;
    logic prev_rs   = 1'b0;

    serial_hba_cmd_ctrl #(.RX_TIMEOUT(50), .XFER_TIMEOUT(20)) dut (
        .hba_clk         (hba_clk),
        .hba_reset       (hba_reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .tx_busy         (tx_busy),
        .read_strobe     (read_strobe),
        .write_strobe    (write_strobe),
        .tx_data         (tx_data),
        .hba_mgrant      (hba_mgrant),
        .hba_xferack     (hba_xferack),
        .hba_dbus        (hba_dbus),
        .masterx_request (masterx_request),
        .master_abus     (master_abus),
        .master_rnw      (master_rnw),
        .master_dbus     (master_dbus),
        .busy            (busy),
        .err             (err)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, check protocol rules, advance the models.
    task automatic tick();
        logic [7:0] d;
        @(negedge hba_clk);
        if (!(masterx_request && hba_mgrant))
            chk("bus_idle_zero", {11'd0, master_rnw, master_abus, master_dbus}, 32'd0);
        else if (master_rnw)
            chk("rd_dbus_zero", {24'd0, master_dbus}, 32'd0);
        if (read_strobe) chk("rs_not_back_to_back", {31'd0, prev_rs}, 32'd0);
        if (write_strobe) chk("ws_while_tx_idle", {31'd0, tx_busy}, 32'd0);
        prev_rs = read_strobe;

        if (write_strobe) begin
            obs_tx.push_back(tx_data);
            tx_cnt = $urandom_range(1, 5);
        end else if (tx_cnt != 0) begin
            tx_cnt--;
        end
        tx_busy = (tx_cnt != 0) || ($urandom_range(0, 3) == 0);

        if (read_strobe && (rxq.size() != 0)) void'(rxq.pop_front());
        if ((rxq.size() != 0) && ($urandom_range(0, 3) != 0)) begin
            rx_valid = 1'b1;
            rx_data  = rxq[0];
        end else begin
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end

        if (!masterx_request) begin
            hba_mgrant  = 1'b0;
            hba_xferack = 1'b0;
            recorded    = 1'b0;
            gnt_dly     = $urandom_range(0, 3);
        end else if (!hba_mgrant) begin
            if (!stall_gnt) begin
                if (gnt_dly == 0) hba_mgrant = 1'b1;
                else gnt_dly--;
            end
        end else if (!hba_xferack) begin
            if (!recorded) begin
                obs_xfer.push_back({master_rnw, master_abus, master_dbus});
                recorded = 1'b1;
                ack_dly  = $urandom_range(0, 3);
            end
            if (!hold_ack) begin
                if (ack_dly == 0) begin
                    if (rd_src.size() != 0) d = rd_src.pop_front();
                    else d = 8'($urandom);
                    hba_xferack = 1'b1;
                    hba_dbus    = d;
                    if (master_rnw) slv_rd.push_back(d);
                end else begin
                    ack_dly--;
                end
            end
        end else begin
            hba_xferack = 1'b0;
        end
    endtask

    // Feeds one packet, waits for it to finish and compares against the reference.
    task automatic run_pkt(input string tag, input logic rnw, input logic [2:0] num,
                           input logic [11:0] addr, input logic [63:0] wd);
        int n;
        int budget;
        n = int'(num) + 1;
        exp_xfer.delete();
        obs_xfer.delete();
        obs_tx.delete();
        slv_rd.delete();
        rxq.push_back({rnw, num, addr[11:8]});
        rxq.push_back(addr[7:0]);
        for (int i = 0; i < n; i++) begin
            logic [11:0] a;
            a = addr + 12'(i);
            if (!rnw) rxq.push_back(wd[8*i +: 8]);
            exp_xfer.push_back({rnw, a, rnw ? 8'h00 : wd[8*i +: 8]});
        end
        budget = 0;
        tick();
        while (((rxq.size() != 0) || busy || read_strobe) && (budget < 3000)) begin
            tick();
            budget++;
        end
        chk({tag, "/completes"}, {31'd0, budget < 3000}, 32'd1);
        chk({tag, "/n_xfer"}, obs_xfer.size(), n);
        for (int i = 0; i < n; i++)
            chk({tag, "/xfer"}, (i < obs_xfer.size()) ? {11'd0, obs_xfer[i]} : 32'hFFFF_FFFF,
                {11'd0, exp_xfer[i]});
        chk({tag, "/n_tx"}, obs_tx.size(), rnw ? n : 0);
        for (int i = 0; i < slv_rd.size(); i++)
            chk({tag, "/tx_byte"}, (i < obs_tx.size()) ? {24'd0, obs_tx[i]} : 32'hFFFF_FFFF,
                {24'd0, slv_rd[i]});
        chk({tag, "/err"}, {31'd0, err}, 32'd0);
        chk({tag, "/busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int b;
        logic       r_rnw;
        logic [2:0] r_num;
        logic [11:0] r_addr;
        logic [63:0] r_wd;

        hba_reset   = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_busy     = 1'b0;
        hba_mgrant  = 1'b0;
        hba_xferack = 1'b0;
        hba_dbus    = 8'h00;
        tick();
        tick();
        chk("rst/request", {31'd0, masterx_request}, 32'd0);
        chk("rst/abus", {20'd0, master_abus}, 32'd0);
        chk("rst/read_strobe", {31'd0, read_strobe}, 32'd0);
        chk("rst/write_strobe", {31'd0, write_strobe}, 32'd0);
        chk("rst/tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst/busy", {31'd0, busy}, 32'd0);
        chk("rst/err", {31'd0, err}, 32'd0);
        hba_reset = 1'b0;
        tick();

        run_pkt("single_wr", 1'b0, 3'd0, 12'h123, 64'hA5);

        rd_src.push_back(8'h11);
        rd_src.push_back(8'h22);
        rd_src.push_back(8'h33);
        rd_src.push_back(8'h44);
        run_pkt("burst_rd", 1'b1, 3'd3, 12'h0FE, 64'd0);
        for (int i = 0; i < 4; i++)
            chk("burst_rd/tx_const", (i < obs_tx.size()) ? {24'd0, obs_tx[i]} : 32'hFFFF_FFFF,
                32'h11 * (i + 1));

        run_pkt("wrap_rd", 1'b1, 3'd1, 12'hFFF, 64'd0);

        for (int k = 0; k < 12; k++) begin
            r_rnw  = 1'($urandom_range(0, 1));
            r_num  = 3'($urandom_range(0, 7));
            r_addr = 12'($urandom);
            r_wd   = {$urandom, $urandom};
            run_pkt("rand_pkt", r_rnw, r_num, r_addr, r_wd);
        end

        // Header byte alone: the receiver must give up after 50 idle cycles.
        rxq.push_back(8'h01);
        b = 0;
        while (!read_strobe && (b < 100)) begin
            tick();
            b++;
        end
        n = 0;
        while (busy && (n < 200)) begin
            n++;
            tick();
        end
        chk("rx_to/busy_cycles", n, 50);
        chk("rx_to/err", {31'd0, err}, 32'd1);
        run_pkt("rx_to/next_wr", 1'b0, 3'd0, 12'h100, 64'h7E);

        // Grant never arrives: request must last exactly 20 cycles.
        stall_gnt = 1'b1;
        obs_xfer.delete();
        rxq.push_back(8'h01);
        rxq.push_back(8'h23);
        rxq.push_back(8'h55);
        b = 0;
        while (!masterx_request && (b < 200)) begin
            tick();
            b++;
        end
        n = 0;
        while (masterx_request && (n < 100)) begin
            n++;
            tick();
        end
        chk("gnt_stall/req_cycles", n, 20);
        chk("gnt_stall/err", {31'd0, err}, 32'd1);
        chk("gnt_stall/busy", {31'd0, busy}, 32'd0);
        chk("gnt_stall/n_xfer", obs_xfer.size(), 0);
        stall_gnt = 1'b0;

        // Reset while a read transfer is on the bus.
        hold_ack = 1'b1;
        obs_xfer.delete();
        rxq.push_back(8'h85);
        rxq.push_back(8'h5A);
        b = 0;
        while (!recorded && (b < 200)) begin
            tick();
            b++;
        end
        chk("rst_xfer/in_xfer_abus", {20'd0, master_abus}, 32'h55A);
        hba_reset = 1'b1;
        #1;
        chk("rst_xfer/request", {31'd0, masterx_request}, 32'd0);
        chk("rst_xfer/abus", {20'd0, master_abus}, 32'd0);
        chk("rst_xfer/rnw", {31'd0, master_rnw}, 32'd0);
        chk("rst_xfer/busy", {31'd0, busy}, 32'd0);
        chk("rst_xfer/err", {31'd0, err}, 32'd0);
        tick();
        hba_reset = 1'b0;
        hold_ack  = 1'b0;
        tick();
        run_pkt("rst_xfer/next_wr", 1'b0, 3'd2, 12'h3C0, 64'h00_0000_00C3_B2A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_hba_cmd_ctrl.md
Name: serial_hba_cmd_ctrl

Overview:
Command sequencer between the buart byte interface and the HBA bus master port inside the serial bridge. It parses a 2-byte header plus optional write data from the UART receiver and issues 1..8 auto-incrementing HBA register transfers. For reads, it returns each byte through the UART transmitter. It owns all UART strobes and all HBA master signals; the bridge top only instantiates and wires it.

Parameters:
RX_TIMEOUT, 1_000_000, idle cycles allowed between bytes of one packet before abort; 0 disables the timeout.
XFER_TIMEOUT, 255, cycles allowed waiting on hba_mgrant plus hba_xferack per transfer before abort; 0 disables the timeout.

Ports:
hba_clk  in  1  sole clock, rising edge.
hba_reset  in  1  asynchronous, active-high reset.
rx_valid  in  1  UART has a received byte.
rx_data  in  8  received byte.
tx_busy  in  1  UART transmitting.
read_strobe  out  1  1-cycle pop of the rx byte.
write_strobe  out  1  1-cycle push of tx_data.
tx_data  out  8  byte to transmit.
hba_mgrant  in  1  master access granted.
hba_xferack  in  1  transfer complete.
hba_dbus  in  8  read data bus.
masterx_request  out  1  bus request.
master_abus  out  12  target address; zero when not granted.
master_rnw  out  1  1 = read, 0 = write; zero when not granted.
master_dbus  out  8  write data; zero when not granted.
busy  out  1  packet in progress (state != IDLE).
err  out  1  sticky timeout flag; cleared by the next valid header byte.

Behaviour:
- Reset (async, hba_reset=1): state IDLE. All outputs are 0. Address and count registers are 0. err is 0.
- Header byte 0 = {rnw, num[2:0], addr[11:8]}. Header byte 1 = addr[7:0]. Transfer count = num+1 (range 1..8).
- A write packet is followed by num+1 data bytes. A read packet has no data bytes and returns num+1 bytes on tx.
- Rx pop rule:
  - In an rx-accepting state, when rx_valid=1 and read_strobe was 0 in the previous cycle, latch rx_data and assert read_strobe for exactly 1 cycle.
  - Never assert read_strobe on consecutive cycles.
- States:
  - IDLE: pop byte -> latch rnw, num, addr_hi; go to ADDR.
  - ADDR: pop byte -> addr_lo. If rnw=1, go to REQ. If rnw=0, go to DATA.
  - DATA: pop byte -> wdata; go to REQ.
  - REQ: masterx_request=1. On hba_mgrant=1, go to XFER. abus, rnw and dbus stay 0 while not granted.
  - XFER:
    - masterx_request=1 and hba_mgrant=1. Drive master_abus=addr and master_rnw=rnw. Drive master_dbus=wdata on writes; it is 0 on reads.
    - On hba_xferack=1, capture hba_dbus on reads, then increment addr mod 4096 (0xFFF wraps to 0x000) and decrement the remaining count.
    - Next state on the same edge: for a read go to TXS; for a write with count remaining go to DATA; for the final write go to IDLE.
    - Bus outputs return to 0 in the cycle after xferack.
  - TXS: when tx_busy=0, drive tx_data=rdata and pulse write_strobe for 1 cycle; go to TXW.
  - TXW: wait at least 1 cycle. Leave when tx_busy=0 again in any cycle after the first. Then go to REQ if count remains, otherwise IDLE.
- Read latency, last XFER to IDLE: xferack -> write_strobe on the 2nd edge at the earliest.
- Timeouts:
  - The rx timer counts cycles spent in ADDR/DATA without a pop and resets on each pop. When it reaches RX_TIMEOUT, set err=1 and go to IDLE.
  - The xfer timer counts cycles spent in REQ+XFER and resets when each transfer begins. When it reaches XFER_TIMEOUT, drop request and all bus outputs in the next cycle, set err=1 and go to IDLE. Remaining bytes are discarded by the header parser as a new packet.
- Simultaneous events:
  - rx_valid during REQ/XFER/TXS/TXW is ignored; the byte stays in the UART.
  - xferack in the same cycle as a timeout: xferack wins and the transfer completes.
  - A reset mid-transfer drops masterx_request asynchronously.
- Write packets produce no tx response.

Decomposition:
- Shared package serial_hba_pkg holds:
  - state enum (IDLE, ADDR, DATA, REQ, XFER, TXS, TXW);
  - header bit-field constants (RNW_BIT=7, NUM_MSB=6, NUM_LSB=4);
  - a 12-bit address width constant.
- One sub-module, serial_hba_timeout: a loadable down-counter with clear, enable, expired and a "parameter 0 = disabled" rule. It is instantiated twice.

Test Plan:
- Single write: rx 0x01,0x23,0xA5 -> one grant cycle with abus=0x123, rnw=0, dbus=0xA5; no write_strobe; busy=0 after xferack.
- Burst read: rx 0xB0,0xFE (num=3, addr 0x0FE), slave returns 0x11,0x22,0x33,0x44 -> abus 0x0FE, 0x0FF, 0x100, 0x101; tx bytes 0x11..0x44 in order; each write_strobe issued only while tx_busy=0.
- Wrap: read header 0x9F,0xFF (num=1) -> abus 0xFFF then 0x000.
- Rx timeout (RX_TIMEOUT=50): send 0x01 only -> after 50 idle cycles err=1 and IDLE; next 0x01,0x00,0x7E performs the write and clears err.
- Grant stall (XFER_TIMEOUT=20): hba_mgrant held 0 -> request drops on cycle 21, err=1, abus stays 0 throughout.
- Reset mid-XFER: hba_reset pulsed while granted -> all outputs 0 immediately, state IDLE, next packet works.
